// File: rtl/mmio_ledsw.sv
// Memory-mapped LED/switch slave with a 32-bit compare timer and interrupt.
// Switches are synchronised and debounced as a whole vector before the core sees them.
module mmio_ledsw #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_7800,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR,
    output logic        irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [9:0]    led_q, led_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   cmp_q, cmp_d;
    logic          en_q, en_d;
    logic          ien_q, ien_d;
    logic          pend_q, pend_d;
    logic          irq_q, irq_d;
    logic [9:0]    sync1_q, sync2_q;
    logic [9:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    sw_q, sw_d;

    logic        sel;
    logic        acc;
    logic        wr;
    logic [2:0]  widx;
    logic [31:0] rd_val;
    logic        match;
    logic        unused_bits;

    assign sel         = req && (addr[31:5] == BASE_ADDR[31:5]);
    assign acc         = (state_q == IDLE) && sel;
    assign wr          = acc && we;
    assign widx        = addr[4:2];
    assign match       = en_q && (count_q == cmp_q);
    assign unused_bits = ^addr[1:0];

    assign rdata = rdata_q;
    assign ready = (state_q == RESP);
    assign LEDR  = led_q;
    assign irq   = irq_q;

    function automatic logic [31:0] merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  lanes
    );
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) begin
            if (lanes[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    always_comb begin
        rd_val = 32'h0;
        unique case (widx)
            3'd0:    rd_val = {22'h0, led_q};
            3'd1:    rd_val = {22'h0, sw_q};
            3'd2:    rd_val = count_q;
            3'd3:    rd_val = cmp_q;
            3'd4:    rd_val = {29'h0, pend_q, ien_q, en_q};
            default: rd_val = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (sel) begin
                    state_d = RESP;
                    rdata_d = rd_val;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        led_d   = led_q;
        count_d = en_q ? count_q + 32'd1 : count_q;
        cmp_d   = cmp_q;
        en_d    = en_q;
        ien_d   = ien_q;
        pend_d  = pend_q;
        if (wr && widx == 3'd0) begin
            if (be[0]) led_d[7:0] = wdata[7:0];
            if (be[1]) led_d[9:8] = wdata[9:8];
        end
        if (wr && widx == 3'd2) count_d = merge(count_d, wdata, be);
        if (wr && widx == 3'd3) cmp_d = merge(cmp_q, wdata, be);
        if (wr && widx == 3'd4 && be[0]) begin
            en_d  = wdata[0];
            ien_d = wdata[1];
            if (wdata[2]) pend_d = 1'b0;
        end
        // A fresh match outranks a same-cycle clear
        if (match) pend_d = 1'b1;
        irq_d = pend_q & ien_q;
    end

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        sw_d   = sw_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) sw_d = cand_q;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
            led_q   <= 10'h0;
            count_q <= 32'h0;
            cmp_q   <= 32'hFFFF_FFFF;
            en_q    <= 1'b0;
            ien_q   <= 1'b0;
            pend_q  <= 1'b0;
            irq_q   <= 1'b0;
            sync1_q <= 10'h0;
            sync2_q <= 10'h0;
            cand_q  <= 10'h0;
            cnt_q   <= '0;
            sw_q    <= 10'h0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            ien_q   <= ien_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            sync1_q <= SW;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
        end
    end

endmodule

// File: tb/tb_mmio_ledsw.sv
// Directed + randomized bench for mmio_ledsw against a register-level model.
// Timer expectations are derived from write/read edge indices.
module tb_mmio_ledsw;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        req      = 1'b0;
    logic        we       = 1'b0;
    logic [31:0] addr     = 32'h0;
    logic [31:0] wdata    = 32'h0;
    logic [3:0]  be       = 4'h0;
    logic [31:0] rdata;
    logic        ready;
    logic [9:0]  SW       = 10'h0;
    logic [9:0]  LEDR;
    logic        irq;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [9:0]  m_led;
    logic [31:0] m_cmp;
    logic [31:0] r;
    int          e, nw, nr, nc, got;
    logic [31:0] d, v;
    logic [3:0]  b;

    mmio_ledsw dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .be       (be),
        .rdata    (rdata),
        .ready    (ready),
        .SW       (SW),
        .LEDR     (LEDR),
        .irq      (irq)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transaction; returns read data and the index of the sampling edge.
    task automatic xact(input logic w, input logic [31:0] a,
                        input logic [31:0] dd, input logic [3:0] bb,
                        output logic [31:0] rd, output int edge_n);
        @(negedge CLOCK_50);
        req = 1'b1; we = w; addr = a; wdata = dd; be = bb;
        @(posedge CLOCK_50);
        #1;
        edge_n = cyc - 1;
        req = 1'b0; we = 1'b0;
        @(negedge CLOCK_50);
        check("ready", {31'h0, ready}, 32'h1);
        rd = rdata;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        logic [31:0] x;
        int n;
        xact(1'b0, a, 32'h0, 4'h0, x, n);
        check(tag, x, exp);
    endtask

    initial begin
        // reset
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_ledr", {22'h0, LEDR}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h0);
        reset = 1'b0;
        rd_chk("rst_sw", 32'h7804, 32'h0);
        rd_chk("rst_ctrl", 32'h7810, 32'h0);
        rd_chk("rst_cmp", 32'h780C, 32'hFFFF_FFFF);

        // LED with byte enables
        xact(1'b1, 32'h7800, 32'h0000_03A5, 4'b0011, r, e);
        check("led_3a5", {22'h0, LEDR}, 32'h3A5);
        xact(1'b1, 32'h7800, 32'hFFFF_FFFF, 4'b0001, r, e);
        check("led_3ff", {22'h0, LEDR}, 32'h3FF);
        rd_chk("led_rb", 32'h7800, 32'h0000_03FF);
        m_led = 10'h3FF;
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            if (b[0]) m_led[7:0] = d[7:0];
            if (b[1]) m_led[9:8] = d[9:8];
            xact(1'b1, 32'h7800, d, b, r, e);
            check("led_rand", {22'h0, LEDR}, {22'h0, m_led});
            rd_chk("led_rand_rb", 32'h7800, {22'h0, m_led});
        end

        // read-only and reserved words
        xact(1'b1, 32'h7804, 32'hFFFF_FFFF, 4'hF, r, e);
        rd_chk("sw_ro", 32'h7804, 32'h0);
        for (int i = 5; i < 8; i++) begin
            xact(1'b1, 32'h7800 + 32'(i * 4), 32'hFFFF_FFFF, 4'hF, r, e);
            rd_chk("resv", 32'h7800 + 32'(i * 4), 32'h0);
        end

        // CMP byte lanes
        m_cmp = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++)
                if (b[k]) m_cmp[8*k +: 8] = d[8*k +: 8];
            xact(1'b1, 32'h780C, d, b, r, e);
            rd_chk("cmp_rand", 32'h780C, m_cmp);
        end

        // switch debounce with glitch
        @(negedge CLOCK_50);
        SW = 10'h155;
        repeat (5) @(negedge CLOCK_50);
        SW = 10'h000;
        repeat (3) @(negedge CLOCK_50);
        SW = 10'h155;
        repeat (12) @(negedge CLOCK_50);
        rd_chk("sw_early", 32'h7804, 32'h0);
        repeat (8) @(negedge CLOCK_50);
        rd_chk("sw_late", 32'h7804, 32'h155);

        // timer compare and interrupt
        xact(1'b1, 32'h780C, 32'd10, 4'hF, r, e);
        xact(1'b1, 32'h7808, 32'd0, 4'hF, r, e);
        xact(1'b1, 32'h7810, 32'h3, 4'h1, r, nc);
        check("irq_pre", {31'h0, irq}, 32'h0);
        got = -1;
        for (int i = 0; i < 40; i++) begin
            if (irq === 1'b1) begin
                got = cyc - 1;
                break;
            end
            @(negedge CLOCK_50);
        end
        // 10 increments to reach CMP, then pending edge, then irq register
        check("irq_edge", 32'(got), 32'(nc + 10 + 2));
        rd_chk("ctrl_pend", 32'h7810, 32'h7);
        xact(1'b1, 32'h7810, 32'h4, 4'h1, r, e);
        check("irq_hold", {31'h0, irq}, 32'h1);
        @(negedge CLOCK_50);
        check("irq_drop", {31'h0, irq}, 32'h0);
        rd_chk("ctrl_clr", 32'h7810, 32'h0);

        // counter wrap and write-over-increment
        xact(1'b1, 32'h7810, 32'h1, 4'h1, r, e);
        xact(1'b1, 32'h7808, 32'hFFFF_FFFE, 4'hF, r, nw);
        repeat (2) @(negedge CLOCK_50);
        xact(1'b0, 32'h7808, 32'h0, 4'h0, r, nr);
        check("count_wrap", r, 32'hFFFF_FFFE + 32'(nr - nw - 1));
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            xact(1'b1, 32'h7808, v, 4'hF, r, nw);
            xact(1'b0, 32'h7808, 32'h0, 4'h0, r, nr);
            check("count_wr", r, v + 32'(nr - nw - 1));
        end
        xact(1'b1, 32'h7810, 32'h0, 4'b1110, r, e);
        rd_chk("ctrl_lane", 32'h7810, 32'h1);
        xact(1'b1, 32'h7810, 32'h0, 4'h1, r, e);

        // outside the window
        @(negedge CLOCK_50);
        req = 1'b1; we = 1'b0; addr = 32'h7820;
        repeat (8) begin
            @(negedge CLOCK_50);
            check("miss_hi", {31'h0, ready}, 32'h0);
        end
        addr = 32'h77FC;
        repeat (4) begin
            @(negedge CLOCK_50);
            check("miss_lo", {31'h0, ready}, 32'h0);
        end
        req = 1'b0;

        // reset while responding
        xact(1'b1, 32'h7800, 32'h2AA, 4'h3, r, e);
        check("led_2aa", {22'h0, LEDR}, 32'h2AA);
        @(negedge CLOCK_50);
        req = 1'b1; we = 1'b0; addr = 32'h7800;
        @(posedge CLOCK_50);
        #1;
        req = 1'b0;
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("resp_ready", {31'h0, ready}, 32'h1);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("rst_resp_ready", {31'h0, ready}, 32'h0);
        check("rst_resp_ledr", {22'h0, LEDR}, 32'h0);
        rd_chk("post_sw", 32'h7804, 32'h0);
        rd_chk("post_led", 32'h7800, 32'h0);
        rd_chk("post_count", 32'h7808, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
